// File: rtl/acq_sequencer.sv
// Acquisition sequencer: pre-trigger fill, trigger wait and post-trigger count on one ADC stream.
// Optional trigger timestamp output is enabled by defining ACQ_SEQ_TIMESTAMP_EN.
module acq_sequencer #(
    parameter int DW = 16,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          ctl_acq,
    input  logic          ctl_stp,
    input  logic          trg_i,
    input  logic [CW-1:0] cfg_pre,
    input  logic [CW-1:0] cfg_pst,
    output logic          sts_run,
    output logic          sts_trg,
    output logic [CW-1:0] sts_pre_cnt,
    output logic [CW-1:0] sts_pst_cnt,
    output logic          irq_o,
    input  logic [DW-1:0] sti_tdata,
    input  logic          sti_tvalid,
    output logic          sti_tready,
    output logic [DW-1:0] sto_tdata,
    output logic          sto_tvalid,
    input  logic          sto_tready,
`ifdef ACQ_SEQ_TIMESTAMP_EN
    output logic [63:0]   sts_trg_ts,
`endif
    output logic          sto_tlast
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PRE  = 2'd1;
    localparam logic [1:0] ARM  = 2'd2;
    localparam logic [1:0] POST = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] pre_cnt;
    logic [CW-1:0] pst_cnt;
    logic [CW-1:0] pst_lim;
    logic [CW:0]   pre_next;
    logic [CW:0]   pst_next;
    logic          running;
    logic          xfer;
    logic          run_xfer;
    logic          start;
    logic          pre_done;
    logic          pst_done;

    assign running    = (state != IDLE);
    assign sti_tready = running ? (~sto_tvalid | sto_tready) : 1'b1;
    assign xfer       = sti_tvalid & sti_tready;
    // A beat arriving in the stop cycle is dropped so an aborted run never emits TLAST.
    assign run_xfer   = xfer & running & ~ctl_stp;
    assign start      = (state == IDLE) & ctl_acq & ~ctl_stp;

    assign pst_lim  = (cfg_pst == '0) ? CW'(1) : cfg_pst;
    assign pre_next = {1'b0, pre_cnt} + (CW+1)'(1);
    assign pst_next = {1'b0, pst_cnt} + (CW+1)'(1);
    assign pre_done = run_xfer & (state == PRE)  & (pre_next >= {1'b0, cfg_pre});
    assign pst_done = run_xfer & (state == POST) & (pst_next >= {1'b0, pst_lim});

    assign sts_run     = running;
    assign sts_trg     = (state == POST);
    assign sts_pre_cnt = pre_cnt;
    assign sts_pst_cnt = pst_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            pre_cnt <= '0;
            pst_cnt <= '0;
            irq_o   <= 1'b0;
        end else begin
            irq_o <= pst_done;
            if (running && ctl_stp) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state   <= (cfg_pre == '0) ? ARM : PRE;
                            pre_cnt <= '0;
                            pst_cnt <= '0;
                        end
                    end
                    PRE: begin
                        if (run_xfer) begin
                            pre_cnt <= pre_cnt + CW'(1);
                        end
                        if (pre_done) begin
                            state <= ARM;
                        end
                    end
                    ARM: begin
                        if (run_xfer && !(&pre_cnt)) begin
                            pre_cnt <= pre_cnt + CW'(1);
                        end
                        if (trg_i) begin
                            state <= POST;
                        end
                    end
                    POST: begin
                        if (run_xfer) begin
                            pst_cnt <= pst_cnt + CW'(1);
                        end
                        if (pst_done) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sto_tdata  <= '0;
            sto_tvalid <= 1'b0;
            sto_tlast  <= 1'b0;
        end else if (run_xfer) begin
            sto_tdata  <= sti_tdata;
            sto_tvalid <= 1'b1;
            sto_tlast  <= pst_done;
        end else if (sto_tready) begin
            sto_tvalid <= 1'b0;
            sto_tlast  <= 1'b0;
        end
    end

`ifdef ACQ_SEQ_TIMESTAMP_EN
    logic [63:0] ts_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ts_cnt     <= '0;
            sts_trg_ts <= '0;
        end else begin
            ts_cnt <= ts_cnt + 64'd1;
            if (start) begin
                sts_trg_ts <= '0;
            end else if ((state == ARM) && trg_i && !ctl_stp) begin
                sts_trg_ts <= ts_cnt;
            end
        end
    end
`endif

endmodule
